// File: rtl/fifo_fwft_prog_pkg.sv
// ---------------------------------------------------------------------------
// fifo_fwft_prog_pkg
// Shared definitions for the FWFT FIFO family.
// ptr_bits() gives the width of read/write pointers and occupancy counts.
// It is one bit wider than the address so that a full FIFO and an empty
// FIFO can be told apart. Future async FIFO variants reuse this helper.
// No ports (package).
// ---------------------------------------------------------------------------
package fifo_fwft_prog_pkg;

  function automatic int ptr_bits(input int addr_bits);
    return addr_bits + 1;
  endfunction

endpackage

// File: rtl/fifo_fwft_prog_if.sv
// ---------------------------------------------------------------------------
// fifo_fwft_prog_if
// Write side, read side, flush and status bundle of the FWFT FIFO.
//   master : drives flush, en_w, data_w, en_r; observes all status
//   slave  : the FIFO itself
// Signals:
//   flush, en_w, data_w[DATA_BITS], en_r            -> FIFO
//   full_w, afull_w, space_count[ADDR_BITS+1],
//   overflow, data_r[DATA_BITS], valid_r, aempty_r,
//   data_count[ADDR_BITS+1], underflow              <- FIFO
// ---------------------------------------------------------------------------
interface fifo_fwft_prog_if
  import fifo_fwft_prog_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 8
) ();
  localparam int PW = ptr_bits(ADDR_BITS);

  logic                 flush;
  logic                 en_w;
  logic [DATA_BITS-1:0] data_w;
  logic                 full_w;
  logic                 afull_w;
  logic [PW-1:0]        space_count;
  logic                 overflow;
  logic                 en_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 aempty_r;
  logic [PW-1:0]        data_count;
  logic                 underflow;

  modport master (
    output flush, en_w, data_w, en_r,
    input  full_w, afull_w, space_count, overflow,
    input  data_r, valid_r, aempty_r, data_count, underflow
  );

  modport slave (
    input  flush, en_w, data_w, en_r,
    output full_w, afull_w, space_count, overflow,
    output data_r, valid_r, aempty_r, data_count, underflow
  );
endinterface

// File: rtl/fifo_fwft_prog_dpram.sv
// ---------------------------------------------------------------------------
// fifo_dpram
// Simple dual-port synchronous RAM: one write port and one registered read
// port. A read of the address being written in the same cycle returns the
// old contents; the FIFO top level covers that case with its bypass path.
// Ports:
//   clk                  clock
//   we, waddr, wdata     write port
//   raddr, rdata         read port, rdata valid one cycle after raddr
// ---------------------------------------------------------------------------
module fifo_dpram #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo_fwft_prog.sv
// ---------------------------------------------------------------------------
// fifo_fwft_prog
// Synchronous first-word-fall-through FIFO, 2^ADDR_BITS words, no sacrificed
// slot. The head word is presented on data_r/valid_r without a read request.
// Programmable almost-full/almost-empty levels, synchronous flush, sticky
// overflow/underflow flags and optional rising-edge qualification of the
// enables.
// Ports:
//   clk  clock (rising edge)
//   rst  synchronous active-high reset (also clears sticky flags)
//   bus  fifo_fwft_prog_if.slave: flush, en_w, data_w, en_r in;
//        full_w, afull_w, space_count, overflow, data_r, valid_r,
//        aempty_r, data_count, underflow out
// ---------------------------------------------------------------------------
module fifo_fwft_prog
  import fifo_fwft_prog_pkg::*;
#(
  parameter int DATA_BITS       = 32,
  parameter int ADDR_BITS       = 8,
  parameter int AFULL_LEVEL     = (1 << ADDR_BITS) - 2,
  parameter int AEMPTY_LEVEL    = 1,
  parameter bit DETECT_WEN_EDGE = 1'b0,
  parameter bit DETECT_REN_EDGE = 1'b0
) (
  input logic             clk,
  input logic             rst,
  fifo_fwft_prog_if.slave bus
);
  localparam int            PW       = ptr_bits(ADDR_BITS);
  localparam int            DEPTH    = 1 << ADDR_BITS;
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P    = {{(PW-1){1'b0}}, 1'b1};
  // A level above DEPTH can never be reached, so almost-full is tied off.
  localparam bit            AFULL_EN = (AFULL_LEVEL <= DEPTH);
  localparam logic [PW-1:0] AFULL_P  = PW'(AFULL_EN ? AFULL_LEVEL : 0);
  localparam logic [PW-1:0] AEMPTY_P = PW'((AEMPTY_LEVEL >= DEPTH) ? DEPTH : AEMPTY_LEVEL);

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        count;
  logic [PW-1:0]        rd_addr_next;
  logic                 en_w_prev;
  logic                 en_r_prev;
  logic                 wen;
  logic                 ren;
  logic                 full;
  logic                 valid;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 ovf;
  logic                 unf;
  logic                 bypass_sel;
  logic [DATA_BITS-1:0] bypass_data;
  logic [DATA_BITS-1:0] ram_q;

  always_comb begin
    wen   = DETECT_WEN_EDGE ? (bus.en_w & ~en_w_prev) : bus.en_w;
    ren   = DETECT_REN_EDGE ? (bus.en_r & ~en_r_prev) : bus.en_r;
    full  = (count == DEPTH_P);
    valid = (count != '0);
    // Flags as they stand at the start of the cycle decide acceptance;
    // flush overrides both requests.
    wr_acc = wen & ~full & ~bus.flush;
    rd_acc = ren & valid & ~bus.flush;
    // Address of the word that will be the head after this edge. The RAM
    // read port is aimed there so the next word is ready one cycle later.
    rd_addr_next = rd_acc ? (rd_ptr + ONE_P) : rd_ptr;
  end

  fifo_dpram #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_BITS-1:0]),
    .wdata (bus.data_w),
    .raddr (rd_addr_next[ADDR_BITS-1:0]),
    .rdata (ram_q)
  );

  // Edge-detect history, pointers, occupancy and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      en_w_prev <= 1'b0;
      en_r_prev <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      en_w_prev <= bus.en_w;
      en_r_prev <= bus.en_r;
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + ONE_P;
        if (rd_acc) rd_ptr <= rd_ptr + ONE_P;
        unique case ({wr_acc, rd_acc})
          2'b10:   count <= count + ONE_P;
          2'b01:   count <= count - ONE_P;
          default: count <= count;
        endcase
        if (wen & full)   ovf <= 1'b1;
        if (ren & ~valid) unf <= 1'b1;
      end
    end
  end

  // Output bypass: when the word being written becomes the new head, the
  // RAM read port would return stale data, so the word is taken straight
  // from data_w. The bypass is also selected out of reset with zero data so
  // that data_r reads 0 until the first transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bypass_sel  <= 1'b1;
      bypass_data <= '0;
    end else begin
      bypass_sel <= wr_acc & (wr_ptr == rd_addr_next);
      if (wr_acc) bypass_data <= bus.data_w;
    end
  end

  assign bus.data_r      = bypass_sel ? bypass_data : ram_q;
  assign bus.valid_r     = valid;
  assign bus.full_w      = full;
  assign bus.afull_w     = AFULL_EN && (count >= AFULL_P);
  assign bus.aempty_r    = (count <= AEMPTY_P);
  assign bus.space_count = DEPTH_P - count;
  assign bus.data_count  = count;
  assign bus.overflow    = ovf;
  assign bus.underflow   = unf;
endmodule

// File: tb/tb_fifo_fwft_prog.sv
// ---------------------------------------------------------------------------
// tb_fifo_fwft_prog
// Bench for fifo_fwft_prog with DATA_BITS=8, ADDR_BITS=2, AFULL_LEVEL=3,
// AEMPTY_LEVEL=1. Instance A uses plain enables; instance B qualifies en_r
// on its rising edge. A circular-buffer model of each instance is checked
// against the DUT outputs on every falling edge, and directed steps add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_fifo_fwft_prog;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   check_en = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fifo_fwft_prog_if #(.DATA_BITS(8), .ADDR_BITS(2)) bus_a ();
  fifo_fwft_prog_if #(.DATA_BITS(8), .ADDR_BITS(2)) bus_b ();

  fifo_fwft_prog #(
    .DATA_BITS(8), .ADDR_BITS(2), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1),
    .DETECT_WEN_EDGE(1'b0), .DETECT_REN_EDGE(1'b0)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  fifo_fwft_prog #(
    .DATA_BITS(8), .ADDR_BITS(2), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1),
    .DETECT_WEN_EDGE(1'b0), .DETECT_REN_EDGE(1'b1)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // ---------------- model: a 4-entry circular buffer per instance --------
  logic [7:0] m_mem  [2][4];
  int         m_head [2] = '{0, 0};
  int         m_cnt  [2] = '{0, 0};
  bit         m_ovf  [2] = '{0, 0};
  bit         m_unf  [2] = '{0, 0};
  bit         m_pr   [2] = '{0, 0};

  task automatic model_step(input int k, input bit r, input bit f, input bit ew,
                            input logic [7:0] dw, input bit er);
    bit ren;
    int tail;
    ren = (k == 1) ? (er && !m_pr[k]) : er;
    m_pr[k] = r ? 1'b0 : er;
    if (r) begin
      m_cnt[k] = 0; m_head[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
    end else if (f) begin
      m_cnt[k] = 0;
    end else begin
      tail = (m_head[k] + m_cnt[k]) % 4;
      if (ew && m_cnt[k] == 4) m_ovf[k] = 1;
      if (ren && m_cnt[k] == 0) m_unf[k] = 1;
      if (ew && m_cnt[k] < 4) begin
        if (ren && m_cnt[k] > 0) begin
          m_mem[k][tail] = dw;
          m_head[k] = (m_head[k] + 1) % 4;
        end else begin
          m_mem[k][tail] = dw;
          m_cnt[k] = m_cnt[k] + 1;
        end
      end else if (ren && m_cnt[k] > 0) begin
        m_head[k] = (m_head[k] + 1) % 4;
        m_cnt[k] = m_cnt[k] - 1;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst, bus_a.flush, bus_a.en_w, bus_a.data_w, bus_a.en_r);
    model_step(1, rst, bus_b.flush, bus_b.en_w, bus_b.data_w, bus_b.en_r);
  end

  // ---------------- checking ---------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic valid, input logic [7:0] data,
                          input logic full, input logic afull, input logic aempty,
                          input logic [2:0] space, input logic [2:0] cnt,
                          input logic ovf, input logic unf);
    string p;
    p = (k == 0) ? "A" : "B";
    chk({p, ".valid_r"},     valid,  32'(m_cnt[k] > 0));
    if (m_cnt[k] > 0) chk({p, ".data_r"}, data, 32'(m_mem[k][m_head[k]]));
    chk({p, ".full_w"},      full,   32'(m_cnt[k] == 4));
    chk({p, ".afull_w"},     afull,  32'(m_cnt[k] >= 3));
    chk({p, ".aempty_r"},    aempty, 32'(m_cnt[k] <= 1));
    chk({p, ".space_count"}, space,  32'(4 - m_cnt[k]));
    chk({p, ".data_count"},  cnt,    32'(m_cnt[k]));
    chk({p, ".overflow"},    ovf,    32'(m_ovf[k]));
    chk({p, ".underflow"},   unf,    32'(m_unf[k]));
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      cmp_inst(0, bus_a.valid_r, bus_a.data_r, bus_a.full_w, bus_a.afull_w,
               bus_a.aempty_r, bus_a.space_count, bus_a.data_count,
               bus_a.overflow, bus_a.underflow);
      cmp_inst(1, bus_b.valid_r, bus_b.data_r, bus_b.full_w, bus_b.afull_w,
               bus_b.aempty_r, bus_b.space_count, bus_b.data_count,
               bus_b.overflow, bus_b.underflow);
    end
  end

  // ---------------- stimulus ---------------------------------------------
  task automatic step_a(input bit f, input bit ew, input logic [7:0] dw, input bit er);
    bus_a.flush = f; bus_a.en_w = ew; bus_a.data_w = dw; bus_a.en_r = er;
    bus_b.flush = 0; bus_b.en_w = 0; bus_b.data_w = 8'h00; bus_b.en_r = 0;
    @(negedge clk);
  endtask

  task automatic step_b(input bit f, input bit ew, input logic [7:0] dw, input bit er);
    bus_b.flush = f; bus_b.en_w = ew; bus_b.data_w = dw; bus_b.en_r = er;
    bus_a.flush = 0; bus_a.en_w = 0; bus_a.data_w = 8'h00; bus_a.en_r = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_a(0, 0, 8'h00, 0);
    rst = 1'b0;
  endtask

  logic [7:0] t4_out [11] = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'h11, 8'h12,
                              8'h13, 8'h14, 8'h15, 8'h16, 8'h17};

  initial begin
    bus_a.flush = 0; bus_a.en_w = 0; bus_a.data_w = 8'h00; bus_a.en_r = 0;
    bus_b.flush = 0; bus_b.en_w = 0; bus_b.data_w = 8'h00; bus_b.en_r = 0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_en = 1'b1;
    chk("rst_data_r",      bus_a.data_r, 8'h00);
    chk("rst_valid_r",     bus_a.valid_r, 0);
    chk("rst_space_count", bus_a.space_count, 4);
    chk("rst_aempty_r",    bus_a.aempty_r, 1);
    chk("rst_afull_w",     bus_a.afull_w, 0);
    rst = 1'b0;

    // 1: single write appears on the output next cycle
    step_a(0, 1, 8'hA1, 0);
    chk("t1_valid", bus_a.valid_r, 1);
    chk("t1_data",  bus_a.data_r, 8'hA1);
    chk("t1_count", bus_a.data_count, 1);
    chk("t1_aempty", bus_a.aempty_r, 1);
    chk("t1_space", bus_a.space_count, 3);
    step_a(0, 0, 8'h00, 0);
    chk("t1_hold", bus_a.data_r, 8'hA1);
    step_a(0, 0, 8'h00, 1);
    chk("t1_empty", bus_a.valid_r, 0);

    // 2: fill, overflow, drain
    for (int i = 1; i <= 4; i++) begin
      step_a(0, 1, 8'(i), 0);
      if (i == 3) chk("t2_afull", bus_a.afull_w, 1);
    end
    chk("t2_full", bus_a.full_w, 1);
    chk("t2_count4", bus_a.data_count, 4);
    step_a(0, 1, 8'h05, 0);
    chk("t2_overflow", bus_a.overflow, 1);
    chk("t2_count_stay", bus_a.data_count, 4);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_rd_data", bus_a.data_r, 8'(i));
      step_a(0, 0, 8'h00, 1);
    end
    chk("t2_drained", bus_a.valid_r, 0);

    // 3: underflow survives flush, cleared by reset
    step_a(0, 0, 8'h00, 1);
    chk("t3_underflow", bus_a.underflow, 1);
    chk("t3_count", bus_a.data_count, 0);
    step_a(1, 0, 8'h00, 0);
    chk("t3_flush_keeps", bus_a.underflow, 1);
    do_reset();
    chk("t3_rst_unf", bus_a.underflow, 0);
    chk("t3_rst_ovf", bus_a.overflow, 0);
    chk("t3_rst_data", bus_a.data_r, 8'h00);

    // 4: full with simultaneous write and read
    for (int i = 0; i < 4; i++) step_a(0, 1, 8'hF0 + 8'(i), 0);
    for (int i = 0; i < 8; i++) begin
      chk("t4_data", bus_a.data_r, t4_out[i]);
      step_a(0, 1, 8'h10 + 8'(i), 1);
      if (i == 0) chk("t4_ovf_first", bus_a.overflow, 1);
      chk("t4_count", bus_a.data_count, 3);
    end
    for (int i = 8; i < 11; i++) begin
      chk("t4_drain", bus_a.data_r, t4_out[i]);
      step_a(0, 0, 8'h00, 1);
    end
    chk("t4_empty", bus_a.valid_r, 0);

    // 5: empty with simultaneous write and read, 1 word/cycle through bypass
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step_a(0, 1, 8'h20 + 8'(i), 1);
      chk("t5_data", bus_a.data_r, 8'h20 + 8'(i));
      chk("t5_count", bus_a.data_count, 1);
      chk("t5_ovf", bus_a.overflow, 0);
    end
    chk("t5_unf", bus_a.underflow, 1);
    step_a(0, 0, 8'h00, 1);
    chk("t5_final", bus_a.data_count, 0);

    // 6: rising-edge read qualification and flush priority on instance B
    step_b(0, 1, 8'hB0, 0);
    step_b(0, 1, 8'hB1, 0);
    step_b(0, 1, 8'hB2, 0);
    chk("t6_count3", bus_b.data_count, 3);
    for (int i = 0; i < 3; i++) step_b(0, 0, 8'h00, 1);
    chk("t6_count2", bus_b.data_count, 2);
    chk("t6_head", bus_b.data_r, 8'hB1);
    step_b(0, 0, 8'h00, 0);
    step_b(0, 0, 8'h00, 1);
    chk("t6_repop", bus_b.data_count, 1);
    chk("t6_head2", bus_b.data_r, 8'hB2);
    step_b(1, 1, 8'h99, 0);
    chk("t6_flush_cnt", bus_b.data_count, 0);
    chk("t6_flush_vld", bus_b.valid_r, 0);
    step_b(0, 0, 8'h00, 0);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
